// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master among NREQ requesters.
// Latches the winner's descriptor, paces i_ready, and reports done/timeout.
module i2c_req_arbiter #(
  parameter int NREQ     = 2,
  parameter int SCLK_DIV = 500,
  parameter int TIMEOUT  = 60000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [4*NREQ-1:0] req_cnt,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   req_err,
  output logic              m_ready,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [3:0]        m_data_cnt,
  input  logic              m_done,
  output logic              busy,
  output logic [1:0]        grant_id
);

  localparam int HOLD_CYC = 2 * SCLK_DIV;
  localparam int TMAX     = (HOLD_CYC > TIMEOUT) ? HOLD_CYC : TIMEOUT;
  localparam int TW       = $clog2(TMAX) + 1;

  localparam logic [TW-1:0] LAUNCH_END  = TW'(SCLK_DIV - 1);
  localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_END    = TW'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FINISH,
    S_HOLDOFF
  } state_t;

  state_t          state, state_d;
  logic [TW-1:0]   timer, timer_d;
  logic [1:0]      last, last_d;
  logic [1:0]      grant_d;
  logic [6:0]      addr_d;
  logic            rw_d;
  logic [3:0]      cnt_d;
  logic            m_ready_d;
  logic            m_done_q;
  logic            done_rise;

  logic            found;
  logic [1:0]      pick;
  logic [6:0]      pick_addr;
  logic            pick_rw;
  logic [3:0]      pick_cnt;
  logic [NREQ-1:0] pick_oh;
  logic [NREQ-1:0] grant_oh;

  assign done_rise = m_done & ~m_done_q;
  assign busy      = (state != S_IDLE);

  // Search last+1 .. last+NREQ (mod NREQ); the first requester found wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    found     = 1'b0;
    pick      = '0;
    pick_addr = '0;
    pick_rw   = 1'b0;
    pick_cnt  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(last) + k) % NREQ)) begin
          found     = 1'b1;
          pick      = 2'(i);
          pick_addr = req_addr[7*i +: 7];
          pick_rw   = req_rw[i];
          pick_cnt  = req_cnt[4*i +: 4];
        end
      end
    end
  end

  always_comb begin
    pick_oh  = '0;
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_oh[i]  = (pick == 2'(i));
      grant_oh[i] = (grant_id == 2'(i));
    end
  end

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    last_d    = last;
    grant_d   = grant_id;
    addr_d    = m_addr;
    rw_d      = m_rw;
    cnt_d     = m_data_cnt;
    m_ready_d = m_ready;
    req_ready = '0;
    req_done  = '0;
    req_err   = '0;

    case (state)
      S_IDLE: begin
        if (found) begin
          req_ready = pick_oh;
          grant_d   = pick;
          last_d    = pick;
          addr_d    = pick_addr;
          rw_d      = pick_rw;
          cnt_d     = pick_cnt;
          m_ready_d = 1'b1;
          timer_d   = '0;
          state_d   = S_LAUNCH;
        end
      end
      // i_ready is held for exactly one sclk period so the master sees it on a single edge.
      S_LAUNCH: begin
        if (timer == LAUNCH_END) begin
          m_ready_d = 1'b0;
          timer_d   = '0;
          state_d   = S_WAIT;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          state_d = S_FINISH;
        end else if (timer == TIMEOUT_END) begin
          req_err = grant_oh;
          timer_d = '0;
          state_d = S_HOLDOFF;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_FINISH: begin
        req_done = grant_oh;
        timer_d  = '0;
        state_d  = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (timer == HOLD_END) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A cycle with reset asserted must not hand out an accept or completion.
    if (rst) begin
      req_ready = '0;
      req_done  = '0;
      req_err   = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      last       <= 2'(NREQ - 1);
      grant_id   <= '0;
      m_addr     <= '0;
      m_rw       <= 1'b0;
      m_data_cnt <= '0;
      m_ready    <= 1'b0;
      m_done_q   <= 1'b0;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      last       <= last_d;
      grant_id   <= grant_d;
      m_addr     <= addr_d;
      m_rw       <= rw_d;
      m_data_cnt <= cnt_d;
      m_ready    <= m_ready_d;
      m_done_q   <= m_done;
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter: scenario tasks plus a pulse scoreboard.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_i2c_req_arbiter;

  localparam int NREQ = 2;
  localparam int S    = 20;
  localparam int T    = 400;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [7*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [4*NREQ-1:0] req_cnt;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_done;
  logic [NREQ-1:0]   req_err;
  logic              m_ready;
  logic [6:0]        m_addr;
  logic              m_rw;
  logic [3:0]        m_data_cnt;
  logic              m_done;
  logic              busy;
  logic [1:0]        grant_id;

  int checks = 0;
  int errors = 0;
  int ready_q[$];
  int done_q[$];
  int err_q[$];

  i2c_req_arbiter #(.NREQ(NREQ), .SCLK_DIV(S), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_rw     (req_rw),
    .req_cnt    (req_cnt),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .req_err    (req_err),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_rw       (m_rw),
    .m_data_cnt (m_data_cnt),
    .m_done     (m_done),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] oh(input int id);
    return NREQ'(1) << id;
  endfunction

  // Advance to the next sample point and score any pulse against its queue.
  task automatic next();
    int e;
    @(negedge clk);
    if (req_ready != '0) begin
      checks++;
      if (ready_q.size() == 0) begin
        errors++;
        $display("FAIL sb_ready: got %b, expected no pulse", req_ready);
      end else begin
        e = ready_q.pop_front();
        if (req_ready !== oh(e)) begin
          errors++;
          $display("FAIL sb_ready: got %b, expected %b", req_ready, oh(e));
        end
      end
    end
    if (req_done != '0) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL sb_done: got %b, expected no pulse", req_done);
      end else begin
        e = done_q.pop_front();
        if (req_done !== oh(e)) begin
          errors++;
          $display("FAIL sb_done: got %b, expected %b", req_done, oh(e));
        end
      end
    end
    if (req_err != '0) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL sb_err: got %b, expected no pulse", req_err);
      end else begin
        e = err_q.pop_front();
        if (req_err !== oh(e)) begin
          errors++;
          $display("FAIL sb_err: got %b, expected %b", req_err, oh(e));
        end
      end
    end
  endtask

  // Move to the drive point just after the next rising edge.
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [6:0] a, input logic rw, input logic [3:0] c);
    req_addr[7*id +: 7] = a;
    req_cnt[4*id +: 4]  = c;
    if (rw) req_rw = req_rw | oh(id);
    else    req_rw = req_rw & ~oh(id);
    req_valid = req_valid | oh(id);
  endtask

  task automatic clr_req(input int id);
    req_valid = req_valid & ~oh(id);
  endtask

  task automatic pulse_reset();
    drv();
    rst = 1'b1;
    next();
    drv();
    rst = 1'b0;
    next();
  endtask

  task automatic wait_grant(input logic [NREQ-1:0] mask, input string name, output int n);
    n = 0;
    do begin
      next();
      n++;
    end while ((req_ready & mask) == '0 && n < 8 * S);
    checks++;
    if ((req_ready & mask) == '0) begin
      errors++;
      $display("FAIL %s_grant: got no req_ready within %0d cycles, required mask %b", name, n, mask);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      next();
      n++;
    end while (busy !== 1'b0 && n < 4 * S);
    checks++;
    if (n != 2 * S + 1) begin
      errors++;
      $display("FAIL %s_holdoff: busy fell after %0d cycles, required %0d", name, n, 2 * S + 1);
    end
  endtask

  task automatic finish_done(input int id, input string name);
    int n = 0;
    drv();
    m_done = 1'b1;
    done_q.push_back(id);
    do begin
      next();
      n++;
    end while (req_done == '0 && n < 5);
    checks++;
    if (n != 2 || req_done !== oh(id)) begin
      errors++;
      $display("FAIL %s_done: got req_done=%b after %0d cycles, required %b after 2", name, req_done, n, oh(id));
    end
    drv();
    m_done = 1'b0;
    wait_idle(name);
  endtask

  // Called in the first LAUNCH cycle; lets WAIT run `delay` cycles before m_done rises.
  task automatic complete_txn(input int id, input int delay, input string name);
    int n = 0;
    while (m_ready === 1'b1 && n < 4 * S) begin
      next();
      n++;
    end
    repeat (delay) next();
    finish_done(id, name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_rw = '0;
    req_cnt = '0;
    m_done = 1'b0;
    repeat (3) next();
    drv();
    rst = 1'b0;
    next();
    checks++;
    if ({busy, m_ready, m_addr, m_rw, m_data_cnt, grant_id, req_ready, req_done, req_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b m_ready=%b addr=%h rw=%b cnt=%h gid=%0d rdy=%b dn=%b er=%b, required all 0",
               busy, m_ready, m_addr, m_rw, m_data_cnt, grant_id, req_ready, req_done, req_err);
    end
  endtask

  task automatic test_single();
    int n;
    int hi;
    drv();
    set_req(0, 7'h50, 1'b0, 4'd3);
    ready_q.push_back(0);
    wait_grant(2'b01, "single", n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL single_accept_latency: got %0d cycles, required 1", n);
    end
    drv();
    clr_req(0);
    next();
    checks++;
    if ({grant_id, m_addr, m_rw, m_data_cnt, m_ready, busy} !== {2'd0, 7'h50, 1'b0, 4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_descriptor: got gid=%0d addr=%h rw=%b cnt=%0d m_ready=%b busy=%b, required 0 50 0 3 1 1",
               grant_id, m_addr, m_rw, m_data_cnt, m_ready, busy);
    end
    hi = 1;
    repeat (S + 3) begin
      next();
      if (m_ready === 1'b1) hi++;
    end
    checks++;
    if (hi != S) begin
      errors++;
      $display("FAIL single_m_ready_width: got %0d cycles, required %0d", hi, S);
    end
    repeat (5 * S) next();
    checks++;
    if (busy !== 1'b1 || m_addr !== 7'h50) begin
      errors++;
      $display("FAIL single_wait_hold: got busy=%b addr=%h, required 1 50", busy, m_addr);
    end
    finish_done(0, "single");
  endtask

  task automatic test_simultaneous();
    int n;
    pulse_reset();
    drv();
    set_req(0, 7'h21, 1'b1, 4'd7);
    set_req(1, 7'h3C, 1'b0, 4'd2);
    ready_q.push_back(0);
    ready_q.push_back(1);
    wait_grant(2'b11, "simul0", n);
    drv();
    clr_req(0);
    next();
    checks++;
    if ({grant_id, m_addr, m_rw, m_data_cnt} !== {2'd0, 7'h21, 1'b1, 4'd7}) begin
      errors++;
      $display("FAIL simul_first: got gid=%0d addr=%h rw=%b cnt=%0d, required 0 21 1 7", grant_id, m_addr, m_rw, m_data_cnt);
    end
    complete_txn(0, 5, "simul0");
    checks++;
    if (req_ready !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_second_grant: got rdy=%b busy=%b at first IDLE, required 10 0", req_ready, busy);
    end
    drv();
    clr_req(1);
    next();
    checks++;
    if ({grant_id, m_addr, m_rw, m_data_cnt} !== {2'd1, 7'h3C, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL simul_second: got gid=%0d addr=%h rw=%b cnt=%0d, required 1 3c 0 2", grant_id, m_addr, m_rw, m_data_cnt);
    end
    complete_txn(1, 5, "simul1");
  endtask

  task automatic test_fairness();
    int n;
    drv();
    set_req(0, 7'h11, 1'b0, 4'd1);
    set_req(1, 7'h12, 1'b1, 4'd4);
    for (int t = 0; t < 4; t++) ready_q.push_back(t % 2);
    for (int t = 0; t < 4; t++) begin
      if (t == 0) wait_grant(2'b11, "fair", n);
      checks++;
      if (req_ready !== oh(t % 2)) begin
        errors++;
        $display("FAIL fair_order: transaction %0d got rdy=%b, required %b", t, req_ready, oh(t % 2));
      end
      drv();
      if (t == 3) begin
        clr_req(0);
        clr_req(1);
      end
      next();
      complete_txn(t % 2, 3, "fair");
    end
  endtask

  task automatic test_timeout();
    int n;
    int k;
    drv();
    set_req(1, 7'h44, 1'b1, 4'd0);
    ready_q.push_back(1);
    err_q.push_back(1);
    wait_grant(2'b10, "timeout", n);
    drv();
    clr_req(1);
    k = 0;
    do begin
      next();
      k++;
    end while (req_err == '0 && k < S + T + 20);
    checks++;
    if (k != S + T) begin
      errors++;
      $display("FAIL timeout_latency: req_err after %0d cycles, required %0d", k, S + T);
    end
    wait_idle("timeout");
  endtask

  task automatic test_stale_done();
    int n;
    int spurious;
    drv();
    set_req(0, 7'h5A, 1'b0, 4'd5);
    ready_q.push_back(0);
    wait_grant(2'b01, "stale", n);
    drv();
    clr_req(0);
    m_done = 1'b1;
    spurious = 0;
    repeat (3 * S) begin
      next();
      if (req_done != '0 || req_err != '0) spurious++;
    end
    checks++;
    if (spurious != 0 || busy !== 1'b1 || m_ready !== 1'b0) begin
      errors++;
      $display("FAIL stale_ignored: got %0d pulses busy=%b m_ready=%b, required 0 1 0", spurious, busy, m_ready);
    end
    drv();
    m_done = 1'b0;
    next();
    finish_done(0, "stale");
  endtask

  task automatic test_reset_in_wait();
    int n;
    int noisy;
    drv();
    set_req(0, 7'h33, 1'b1, 4'd9);
    ready_q.push_back(0);
    wait_grant(2'b01, "rstwait", n);
    drv();
    clr_req(0);
    next();
    n = 0;
    while (m_ready === 1'b1 && n < 4 * S) begin
      next();
      n++;
    end
    repeat (5) next();
    pulse_reset();
    checks++;
    if ({busy, m_ready, m_addr, m_rw, m_data_cnt, grant_id, req_ready, req_done, req_err} !== '0) begin
      errors++;
      $display("FAIL rstwait_outputs: got busy=%b m_ready=%b addr=%h rw=%b cnt=%h gid=%0d rdy=%b dn=%b er=%b, required all 0",
               busy, m_ready, m_addr, m_rw, m_data_cnt, grant_id, req_ready, req_done, req_err);
    end
    noisy = 0;
    repeat (T + S) begin
      next();
      if (busy !== 1'b0 || req_done != '0 || req_err != '0 || req_ready != '0) noisy++;
    end
    checks++;
    if (noisy != 0) begin
      errors++;
      $display("FAIL rstwait_quiet: got %0d active cycles after reset, required 0", noisy);
    end
    drv();
    set_req(0, 7'h0F, 1'b0, 4'd8);
    set_req(1, 7'h66, 1'b0, 4'd6);
    ready_q.push_back(0);
    ready_q.push_back(1);
    wait_grant(2'b11, "rstwait", n);
    checks++;
    if (n != 1 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstwait_priority: got rdy=%b after %0d cycles, required 01 after 1", req_ready, n);
    end
    drv();
    clr_req(0);
    next();
    complete_txn(0, 4, "rstwait0");
    drv();
    clr_req(1);
    next();
    checks++;
    if ({grant_id, m_addr, m_data_cnt} !== {2'd1, 7'h66, 4'd6}) begin
      errors++;
      $display("FAIL rstwait_second: got gid=%0d addr=%h cnt=%0d, required 1 66 6", grant_id, m_addr, m_data_cnt);
    end
    complete_txn(1, 4, "rstwait1");
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_stale_done();
    test_reset_in_wait();
    repeat (3) next();
    checks++;
    if (ready_q.size() + done_q.size() + err_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d ready, %0d done, %0d err still expected, required 0",
               ready_q.size(), done_q.size(), err_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares the single I2C master between NREQ requesters (sensor pollers, config loader, CPU bridge) using round-robin arbitration.
- Latches the winning requester's transaction descriptor (addr, rw, byte count) and drives the master's i_ready/addr/rw/data_cnt inputs.
- Tracks completion through the master's i2c_done and reports done or timeout back to the requester.
- Sits between requesters and the master. TX/RX FIFO data paths are not routed through this block.

Parameters:
- NREQ, 2: number of requesters, legal range 1..4.
- SCLK_DIV, 500: clk cycles per master sclk period. Sets the launch-hold and bus holdoff durations.
- TIMEOUT, 60000: clk cycles allowed in WAIT before the transaction is declared failed.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  NREQ  per-requester request; held with fields stable until req_ready.
- req_addr  in  7*NREQ  7-bit slave address per requester; requester i uses [7i+6:7i].
- req_rw  in  NREQ  direction per requester (0 write, 1 read).
- req_cnt  in  4*NREQ  byte count minus 1 per requester.
- req_ready  out  NREQ  one-cycle one-hot accept pulse.
- req_done  out  NREQ  one-cycle one-hot completion pulse.
- req_err  out  NREQ  one-cycle one-hot timeout pulse.
- m_ready  out  1  to master i_ready.
- m_addr  out  7  to master addr.
- m_rw  out  1  to master rw.
- m_data_cnt  out  4  to master data_cnt.
- m_done  in  1  from master i2c_done; level, may stay high for many clk cycles.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  2  index of current or last granted requester.

Behaviour:
- Reset (rst=1 at posedge clk):
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Timers and m_done_q are cleared.
  - Reset mid-transaction abandons it silently: no done or err pulse. The master is not aborted (it has no abort input).
- Edge detect: m_done_q <= m_done every cycle; done_rise = m_done & ~m_done_q.
- States: IDLE, LAUNCH, WAIT, FINISH, HOLDOFF.
- IDLE:
  - If any req_valid bit is set, search indices last+1 .. last+NREQ modulo NREQ. The first set bit wins, g.
  - Registered same edge: m_addr/m_rw/m_data_cnt <= fields of g; grant_id <= g; last <= g; req_ready[g]=1 for exactly this cycle; timer <= 0; go LAUNCH.
  - With no request, remain in IDLE.
- LAUNCH:
  - m_ready=1, timer increments.
  - When timer == SCLK_DIV-1: m_ready <= 0, timer <= 0, go WAIT.
  - This guarantees the master samples i_ready on exactly one sclk edge and cannot restart after STOP.
- WAIT:
  - m_ready=0, timer increments.
  - On done_rise: go FINISH.
  - Else if timer == TIMEOUT-1: req_err[grant_id]=1 for one cycle, timer <= 0, go HOLDOFF.
  - If done_rise and timeout coincide, done wins.
- FINISH: req_done[grant_id]=1 for one cycle; timer <= 0; go HOLDOFF.
- HOLDOFF:
  - Wait 2*SCLK_DIV cycles (timer reaches 2*SCLK_DIV-1), then go IDLE.
  - This covers the master's STOP-to-IDLE transition and the bus-free time.
  - New requests are not granted in HOLDOFF.
- m_done handling: done_rise outside WAIT is ignored. A level already high on entry to WAIT does not count as done; only a rising edge does.
- Descriptor stability: m_addr/m_rw/m_data_cnt hold from grant until the next grant. A requester dropping req_valid after grant has no effect on the transaction.
- Pulse exclusivity: at most one bit set in each of req_ready, req_done, req_err per cycle, and never both done and err for the same transaction.
- Width rule: timer width is clog2(max(2*SCLK_DIV, TIMEOUT))+1 bits. Comparisons are unsigned.
- Unused requester bits (NREQ < 4) are never granted. grant_id upper bits are 0 when NREQ=2.
- Latency: request accepted in IDLE with req_ready on the same registered edge. m_ready rises 1 cycle after the grant.

Test Plan:
- Single request: req_valid=01, addr=0x50, rw=0, cnt=3 → req_ready=01 pulse, m_addr=0x50, m_data_cnt=3, m_ready high exactly 500 cycles. Model m_done rising at 5000 → req_done=01 one cycle later, busy low 1000 cycles after that.
- Simultaneous: req_valid=11 after reset → requester 0 granted first, requester 1 granted on the first IDLE after holdoff. grant_id sequence 0,1.
- Fairness: requester 0 re-requests immediately each time while requester 1 holds valid → grants alternate 0,1,0,1 over 4 transactions.
- Timeout: grant with m_done stuck low → req_err pulse at cycle SCLK_DIV+TIMEOUT after grant, no req_done, busy returns low after 1000 more cycles.
- Stale done: m_done high during LAUNCH and staying high → no req_done until m_done falls and rises again in WAIT.
- Reset in WAIT: assert rst for 1 cycle → all outputs 0, state IDLE, no done or err pulse. A pending req_valid=10 is then granted to requester 0 first only if set; otherwise requester 1.
